idwt53_reconstruct: RTL and testbench
=====================================

Name: idwt53_reconstruct

Overview:
- Inverse 5/3 integer lifting stage, directly downstream of the forward DWT `top`.
- Consumes one (coarse, detail) coefficient pair per handshake and reconstructs the original sample stream in order (x0, x1, x2, …), one sample per clock.
- Frame boundaries use symmetric extension and are marked by coef_last on the final pair.
- Used for loop-back verification of the forward transform and as the synthesis half of the codec.

Parameters:
DATA_WIDTH, 16, width of coefficients and reconstructed samples (signed two's complement)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
coarse_coefficient  input  DATA_WIDTH  s[n], signed
detail_coefficient  input  DATA_WIDTH  d[n], signed
coef_valid  input  1  pair present on coefficient inputs
coef_last  input  1  current pair is final pair of frame; qualified by coef_valid
coef_ready  output  1  block accepts pair this cycle; transfer = coef_valid & coef_ready
data_out  output  DATA_WIDTH  reconstructed sample, signed
valid_out  output  1  data_out valid this cycle; no downstream backpressure
last_out  output  1  data_out is final sample of frame

Behaviour:
- Reset (rst=0 at clk edge):
  - State -> IDLE; internal x_prev and d_prev cleared.
  - data_out=0, valid_out=0, last_out=0; coef_ready=0 while rst=0.
  - Reset mid-frame discards all pending samples; no partial frame is emitted.
- States: IDLE (no pair held), RUN (x_prev, d_prev held), FLUSH (final odd sample pending).
- Arithmetic:
  - Internal sums are sign-extended to DATA_WIDTH+2 bits.
  - floor() is an arithmetic right shift.
  - Results truncate (wrap) to DATA_WIDTH.
- IDLE accept of pair 0 at cycle t:
  - x0 = s0 - floor((2*d0+2)/4); x0 is output at t+1.
  - If coef_last=0: x_prev=x0, d_prev=d0, state -> RUN.
  - If coef_last=1 (1-pair frame): x1 = d0 + x0 is output at t+2 with last_out=1; state -> IDLE.
- RUN accept of pair n at cycle t:
  - xe = s_n - floor((d_prev+d_n+2)/4).
  - xo = d_prev + floor((x_prev+xe)/2).
  - Output xo at t+1, xe at t+2; then x_prev=xe, d_prev=d_n.
  - If coef_last=1: state -> FLUSH; final xf = d_n + xe is output at t+3 with last_out=1; then IDLE.
- coef_ready in cycle c:
  - Equals 1 iff rst=1 and no sample from an earlier acceptance is scheduled for cycle c+1.
  - After IDLE accept at t: high at t+1.
  - After RUN accept at t: low at t+1, high at t+2.
  - After last accept in RUN at t: low at t+1 and t+2, high at t+3.
  - After single-pair-frame accept at t: low at t+1, high at t+2.
- Throughput:
  - With coef_valid held high, the output stream has no bubbles from the first sample to last_out.
  - A new frame's x0 may follow last_out in the immediately next cycle.
- coef_valid while coef_ready=0: ignored; upstream holds data stable until the transfer.
- coef_last without coef_valid: ignored.
- valid_out=0 implies last_out=0. data_out holds its last value when valid_out=0.

Test Plan:
- Reset, then pairs (s,d) = (2,2), (7,3) with last on the 2nd, coef_valid held high -> accepts at cycles 0 and 1; data_out = 1,5,6,9 at cycles 1-4; last_out only at cycle 4; coef_ready low at cycles 2-3.
- Single-pair frame (s,d) = (-2,3) with last -> data_out = 0xFFFC then 0xFFFF on consecutive cycles; last_out on the 2nd; coef_ready low exactly one cycle.
- 4-pair frame forward-transformed from 1,5,6,9,12,16,18,22, coef_valid held high -> pairs accepted at cycles 0,1,3,5; exact input samples returned at cycles 1-8 with no gaps; last_out at cycle 8.
- Back-to-back frames: second frame's pair 0 presented at last-accept+3 -> its x0 appears on the cycle immediately after the previous last_out.
- Random coef_valid gaps plus values near ±32767 -> output matches a wrap-at-16-bit 5/3 reference model, including floor on negative odd sums.
- rst=0 asserted during a frame after the 2nd pair -> next cycle valid_out=0, data_out=0, last_out=0; fresh frame after release reconstructs correctly from x0.

Source files
------------

// File: rtl/idwt53_reconstruct.sv
// Inverse 5/3 integer lifting stage. Takes one (coarse, detail) pair per handshake and
// emits the reconstructed sample stream x0, x1, x2, ... one sample per clock, using
// symmetric extension at both frame edges.
module idwt53_reconstruct #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] coarse_coefficient,
  input  logic signed [DATA_WIDTH-1:0] detail_coefficient,
  input  logic                         coef_valid,
  input  logic                         coef_last,
  output logic                         coef_ready,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid_out,
  output logic                         last_out
);

  localparam int unsigned EW = DATA_WIDTH + 2;
  localparam logic signed [EW-1:0] Two = EW'(2);

  // StIdle/StRun accept pairs; the rest drain samples already owed downstream.
  // StEven:     even sample of a mid-frame pair pending (x_prev holds it).
  // StEvenLast: even sample of the final pair pending, tail sample follows.
  // StFlush:    tail sample d_prev + x_prev pending after a multi-pair frame.
  // StSingle:   x1 = d0 + x0 pending after a one-pair frame.
  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StEven,
    StEvenLast,
    StFlush,
    StSingle
  } state_e;

  state_e                       state;
  logic signed [DATA_WIDTH-1:0] x_prev;
  logic signed [DATA_WIDTH-1:0] d_prev;

  logic signed [EW-1:0]         s_ext;
  logic signed [EW-1:0]         d_ext;
  logic signed [EW-1:0]         xp_ext;
  logic signed [EW-1:0]         dp_ext;
  logic signed [EW-1:0]         xe_ext;
  logic signed [EW-1:0]         edge_sum;
  logic signed [EW-1:0]         run_sum;
  logic signed [EW-1:0]         odd_sum;
  logic signed [DATA_WIDTH-1:0] x_first;
  logic signed [DATA_WIDTH-1:0] x_even;
  logic signed [DATA_WIDTH-1:0] x_odd;
  logic signed [DATA_WIDTH-1:0] x_tail;
  logic                         accept;

  // Lifting arithmetic on sign-extended operands; >>> gives floor, results wrap.
  always_comb begin
    s_ext    = {{2{coarse_coefficient[DATA_WIDTH-1]}}, coarse_coefficient};
    d_ext    = {{2{detail_coefficient[DATA_WIDTH-1]}}, detail_coefficient};
    xp_ext   = {{2{x_prev[DATA_WIDTH-1]}}, x_prev};
    dp_ext   = {{2{d_prev[DATA_WIDTH-1]}}, d_prev};
    // Left edge: d[-1] mirrors d[0].
    edge_sum = (d_ext <<< 1) + Two;
    x_first  = DATA_WIDTH'(s_ext - (edge_sum >>> 2));
    run_sum  = dp_ext + d_ext + Two;
    x_even   = DATA_WIDTH'(s_ext - (run_sum >>> 2));
    xe_ext   = {{2{x_even[DATA_WIDTH-1]}}, x_even};
    odd_sum  = xp_ext + xe_ext;
    x_odd    = DATA_WIDTH'(dp_ext + (odd_sum >>> 1));
    // Right edge: x[2N] mirrors x[2N-2], so the last odd sample is d + x_even.
    x_tail   = d_prev + x_prev;
    // Ready only when no sample from an earlier pair still has to go out next cycle.
    coef_ready = rst && ((state == StIdle) || (state == StRun));
    accept     = coef_valid && coef_ready;
  end

  // Control FSM with registered sample outputs; data_out holds when nothing is emitted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= StIdle;
      x_prev    <= '0;
      d_prev    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      case (state)
        StIdle: begin
          if (accept) begin
            data_out  <= x_first;
            valid_out <= 1'b1;
            x_prev    <= x_first;
            d_prev    <= detail_coefficient;
            state     <= coef_last ? StSingle : StRun;
          end
        end
        StRun: begin
          if (accept) begin
            data_out  <= x_odd;
            valid_out <= 1'b1;
            x_prev    <= x_even;
            d_prev    <= detail_coefficient;
            state     <= coef_last ? StEvenLast : StEven;
          end
        end
        StEven: begin
          data_out  <= x_prev;
          valid_out <= 1'b1;
          state     <= StRun;
        end
        StEvenLast: begin
          data_out  <= x_prev;
          valid_out <= 1'b1;
          state     <= StFlush;
        end
        StFlush, StSingle: begin
          data_out  <= x_tail;
          valid_out <= 1'b1;
          last_out  <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_idwt53_reconstruct.sv
// Scoreboard bench for idwt53_reconstruct: a 5/3 inverse reference model queues expected
// samples on each accepted pair; a monitor pops and compares as the DUT emits samples.
module tb_idwt53_reconstruct;

  typedef struct {
    logic signed [15:0] s;
    logic signed [15:0] d;
    bit                 last;
  } pair_t;

  typedef struct {
    logic [15:0] data;
    bit          last;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    bit          last;
    int          cyc;
  } obs_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] coarse_coefficient = '0;
  logic signed [15:0] detail_coefficient = '0;
  logic               coef_valid = 1'b0;
  logic               coef_last = 1'b0;
  logic               coef_ready;
  logic signed [15:0] data_out;
  logic               valid_out;
  logic               last_out;

  pair_t stim_q[$];
  exp_t  exp_q[$];
  obs_t  log_q[$];
  int    acc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  // Reference model state
  int    mxp = 0;
  int    mdp = 0;
  bit    mrun = 1'b0;

  idwt53_reconstruct #(.DATA_WIDTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .coarse_coefficient (coarse_coefficient),
    .detail_coefficient (detail_coefficient),
    .coef_valid         (coef_valid),
    .coef_last          (coef_last),
    .coef_ready         (coef_ready),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .last_out           (last_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] wrap(input int v);
    return v[15:0];
  endfunction

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic void push_exp(input logic [15:0] v, input bit l);
    exp_t e;
    e.data = v;
    e.last = l;
    exp_q.push_back(e);
  endfunction

  // Inverse 5/3 written directly from the lifting equations, 16-bit wrap per sample.
  function automatic void model_accept(input int s, input int d, input bit last);
    int x0, xe, xo;
    if (!mrun) begin
      x0 = sx(wrap(s - ((2 * d + 2) >>> 2)));
      push_exp(wrap(x0), 1'b0);
      if (last) push_exp(wrap(d + x0), 1'b1);
      else begin
        mxp  = x0;
        mdp  = d;
        mrun = 1'b1;
      end
    end else begin
      xe = sx(wrap(s - ((mdp + d + 2) >>> 2)));
      xo = sx(wrap(mdp + ((mxp + xe) >>> 1)));
      push_exp(wrap(xo), 1'b0);
      push_exp(wrap(xe), 1'b0);
      if (last) begin
        push_exp(wrap(d + xe), 1'b1);
        mrun = 1'b0;
      end else begin
        mxp = xe;
        mdp = d;
      end
    end
  endfunction

  // Output monitor, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    obs_t o;
    exp_t e;
    #1;
    if (rst) begin
      if (valid_out) begin
        o.data = data_out;
        o.last = last_out;
        o.cyc  = cyc;
        log_q.push_back(o);
        check_eq("sample_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("data_out", $unsigned(data_out), e.data);
          check_eq("last_out", last_out, e.last);
        end
      end else if (last_out) begin
        check_eq("last_without_valid", last_out, 1'b0);
      end
    end
  end

  // Present queued pairs; with gaps set, coef_valid drops at random.
  task automatic drive_all(input bit gaps);
    int guard = 0;
    while (stim_q.size() > 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        coef_valid = 1'b0;
        coef_last  = $urandom_range(0, 1);
      end else begin
        coef_valid         = 1'b1;
        coarse_coefficient = stim_q[0].s;
        detail_coefficient = stim_q[0].d;
        coef_last          = stim_q[0].last;
      end
      #1;
      if (coef_valid && coef_ready) begin
        model_accept(int'(stim_q[0].s), int'(stim_q[0].d), stim_q[0].last);
        acc_q.push_back(cyc);
        void'(stim_q.pop_front());
      end
    end
    check_eq("drive_done", stim_q.size(), 0);
    @(negedge clk);
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk);
    #2;
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic add_pair(input int s, input int d, input bit l);
    pair_t p;
    p.s    = 16'(s);
    p.d    = 16'(d);
    p.last = l;
    stim_q.push_back(p);
  endtask

  // Compare the logged samples against a fixed list: values, contiguous cycles, final last.
  task automatic check_log(input string tag, input int ev[$], input int first_cyc);
    check_eq({tag, "_count"}, log_q.size(), ev.size());
    for (int i = 0; i < ev.size() && i < log_q.size(); i++) begin
      check_eq({tag, "_val"}, log_q[i].data, wrap(ev[i]));
      check_eq({tag, "_cyc"}, log_q[i].cyc, first_cyc + i);
      check_eq({tag, "_lastflag"}, log_q[i].last, i == ev.size() - 1);
    end
  endtask

  task automatic clear_logs();
    log_q.delete();
    acc_q.delete();
  endtask

  initial begin
    int ev[$];
    int n;
    int v;

    // Reset, with coef_valid asserted to show it is ignored.
    coef_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid_out", valid_out, 1'b0);
    check_eq("rst_data_out", $unsigned(data_out), 16'h0);
    check_eq("rst_last_out", last_out, 1'b0);
    check_eq("rst_coef_ready", coef_ready, 1'b0);
    coef_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", coef_ready, 1'b1);

    // Two-pair frame, valid held high.
    clear_logs();
    add_pair(2, 2, 0);
    add_pair(7, 3, 1);
    drive_all(0);
    check_eq("t1_ready_t1", coef_ready, 1'b0);
    @(negedge clk); #1;
    check_eq("t1_ready_t2", coef_ready, 1'b0);
    @(negedge clk); #1;
    check_eq("t1_ready_t3", coef_ready, 1'b1);
    drain();
    check_eq("t1_acc_gap", acc_q[1] - acc_q[0], 1);
    ev = '{1, 5, 6, 9};
    check_log("t1", ev, acc_q[0] + 1);

    // Single-pair frame.
    clear_logs();
    add_pair(-2, 3, 1);
    drive_all(0);
    check_eq("t2_ready_t1", coef_ready, 1'b0);
    @(negedge clk); #1;
    check_eq("t2_ready_t2", coef_ready, 1'b1);
    drain();
    ev = '{16'hFFFC, 16'hFFFF};
    check_log("t2", ev, acc_q[0] + 1);

    // Four-pair frame from forward transform of 1,5,6,9,12,16,18,22.
    clear_logs();
    add_pair(2, 2, 0);
    add_pair(7, 0, 0);
    add_pair(12, 1, 0);
    add_pair(19, 4, 1);
    drive_all(0);
    drain();
    check_eq("t3_acc1", acc_q[1] - acc_q[0], 1);
    check_eq("t3_acc2", acc_q[2] - acc_q[0], 3);
    check_eq("t3_acc3", acc_q[3] - acc_q[0], 5);
    ev = '{1, 5, 6, 9, 12, 16, 18, 22};
    check_log("t3", ev, acc_q[0] + 1);

    // Back-to-back frames: next x0 directly after last_out.
    clear_logs();
    add_pair(2, 2, 0);
    add_pair(7, 3, 1);
    add_pair(-2, 3, 1);
    drive_all(0);
    drain();
    check_eq("t4_acc_next", acc_q[2] - acc_q[1], 3);
    check_eq("t4_count", log_q.size(), 6);
    if (log_q.size() >= 5) begin
      check_eq("t4_prev_last", log_q[3].last, 1'b1);
      check_eq("t4_next_x0", log_q[4].data, 16'hFFFC);
      check_eq("t4_adjacent", log_q[4].cyc - log_q[3].cyc, 1);
    end

    // Random frames, gaps and near-full-scale values.
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        pair_t p;
        for (int j = 0; j < 2; j++) begin
          case ($urandom_range(0, 3))
            0:       v = 32767 - $urandom_range(0, 3);
            1:       v = -32768 + $urandom_range(0, 3);
            2:       v = $urandom_range(0, 15) - 8;
            default: v = $urandom_range(0, 65535) - 32768;
          endcase
          if (j == 0) p.s = 16'(v);
          else p.d = 16'(v);
        end
        p.last = (k == n - 1);
        stim_q.push_back(p);
      end
    end
    drive_all(1);
    drain();

    // Reset in the middle of a frame after its second pair.
    clear_logs();
    add_pair(2, 2, 0);
    add_pair(7, 0, 0);
    drive_all(0);
    rst = 1'b0;
    exp_q.delete();
    mrun = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", valid_out, 1'b0);
    check_eq("mid_rst_data", $unsigned(data_out), 16'h0);
    check_eq("mid_rst_last", last_out, 1'b0);
    check_eq("mid_rst_ready", coef_ready, 1'b0);
    rst = 1'b1;
    clear_logs();
    add_pair(2, 2, 0);
    add_pair(7, 0, 0);
    add_pair(12, 1, 0);
    add_pair(19, 4, 1);
    drive_all(0);
    drain();
    ev = '{1, 5, 6, 9, 12, 16, 18, 22};
    check_log("t6", ev, acc_q[0] + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
